jt89_cpu_if: RTL and testbench
==============================

# jt89_cpu_if

CPU-side register interface for the JT89 PSG. Decodes the SN76489 byte-write protocol (latch/data bytes) into the per-channel register file that drives the three tone channels and the noise channel: 10-bit tone periods, 4-bit attenuations, the 3-bit noise control and the one-cycle LFSR clear. Also generates the chip's READY handshake back to the CPU. Sits between the host bus and the jt89 channel instances.

## Interface
- `READY_CYCLES`, default 32: clk cycles READY stays low after an accepted write; legal range 1..255.

- `clk` input 1: system clock, same clock as the channel blocks.
- `rst` input 1: reset, synchronous, active-high.
- `cs_n` input 1: chip select, active low.
- `wr_n` input 1: write strobe, active low.
- `din` input 8: CPU data byte.
- `ready` output 1: high when the chip can accept a write; low while a write is being absorbed.
- `tone0`, `tone1`, `tone2` output 10 each: tone period registers.
- `vol0`, `vol1`, `vol2`, `vol3` output 4 each: attenuation, where 0 = loudest and F = off. `vol3` is the noise channel.
- `ctrl3` output 3: noise control. Bit 2 = white/periodic; bits 1:0 = rate select.
- `clr` output 1: one-cycle pulse that resets the noise LFSR.

## Operation
- Strobe `s = ~cs_n & ~wr_n`, registered as `s_q`. A write is accepted at a clk edge where `s`=1 and `s_q`=0. `din` is sampled at that same edge.
- Holding the strobe low produces exactly one write. A new write needs `s` to return to 0 for at least one edge.
- **Latch byte** (`din[7]`=1):
  - Sets latch register `lat` = {`din[6:5]` channel, `din[4]` type}, where type 1 = volume.
  - Writes `din[3:0]` into the addressed register:
    - tone: low nibble, `tone[3:0]`;
    - volume: `vol`;
    - noise control (ch3, type 0): `ctrl3` = `din[2:0]` and pulses `clr`.
- **Data byte** (`din[7]`=0): targets the register held in `lat`.
  - tone: `tone[9:4]` = `din[5:0]`.
  - volume: `vol` = `din[3:0]`.
  - noise control: `ctrl3` = `din[2:0]` and pulses `clr`.
- Ch3 type 0 has no tone register. `tone2` is never written by a noise-control access.
- Writes accepted while `ready`=0 are still executed and restart the READY counter. The block never drops a write.
- Reset values:
  - `tone0..2` = 0
  - `vol0..3` = 4'hF
  - `ctrl3` = 0
  - `lat` = {ch0, tone}
  - `clr` = 0
  - `ready` = 1
  - `s_q` = 1, so a strobe that is already low when reset is released is not a write.

## Timing
- Register outputs change on the accepting edge. They are visible in the cycle after it, giving a latency of 1 clk from the strobe being sampled.
- `clr` is high for exactly the single cycle following the accepting edge, with no clk_en gating. Back-to-back noise writes give one pulse each.
- READY counter:
  - loads READY_CYCLES on the accepting edge;
  - `ready`=0 while the counter is nonzero;
  - the counter decrements every clk.
  - `ready` therefore returns high READY_CYCLES cycles after the accepting edge.
- `rst` during a busy period forces `ready`=1, clears the counter and kills any `clr` pulse. `rst` has priority over a simultaneous write.
- Counter width is 8 bits. There is no wrap-around: the counter saturates at 0.

## Structure
- Shared package `jt89_pkg`:
  - channel index constants `CH_TONE0..CH_NOISE`;
  - type constants `RT_TONE`/`RT_VOL`;
  - reset constant `VOL_OFF` = 4'hF.
- One sub-module: `jt89_wr_edge`. It owns the strobe combination, the `s_q` register and the single-cycle `we` output.
- Register file and READY counter stay in `jt89_cpu_if`. Target 150–250 lines.

## Test plan
- Reset: after `rst`, all tones = 0, all vols = F, `ctrl3` = 0, `ready` = 1, `clr` = 0. A strobe held low through reset release produces no write.
- Write 8'h8E then 8'h0F → `tone0` = 10'h0FE. Then write 8'h03 → `tone0` = 10'h03E, with the low nibble kept.
- Write 8'hBF → `vol1` = F. Then data 8'h02 → `vol1` = 2. `tone1` is unchanged throughout.
- Write 8'hE5 → `ctrl3` = 3'b101, `clr` high for exactly 1 cycle. Then data 8'h03 → `ctrl3` = 3'b011 and a second 1-cycle `clr`. `tone2` is unchanged.
- READY_CYCLES=32: after a write, `ready` is low for exactly 32 cycles. A second write at cycle 10 executes and keeps `ready` low until 32 cycles after it. A strobe held low for 100 cycles yields one write.
- Assert `rst` at cycle 5 of busy → `ready` = 1 next cycle, registers at reset values.

Source files
------------

// File: rtl/jt89_pkg.sv
// jt89_pkg: shared constants and types for the JT89 CPU-side register interface.
// Holds the channel/register-type encodings used by the SN76489 latch/data byte protocol
// and the attenuation reset value ("off").
package jt89_pkg;

  // Channel indices as carried in din[6:5] of a latch byte
  localparam logic [1:0] CH_TONE0 = 2'd0;
  localparam logic [1:0] CH_TONE1 = 2'd1;
  localparam logic [1:0] CH_TONE2 = 2'd2;
  localparam logic [1:0] CH_NOISE = 2'd3;

  // Register type as carried in din[4] of a latch byte
  localparam logic RT_TONE = 1'b0;
  localparam logic RT_VOL  = 1'b1;

  // Attenuation value meaning "silent"
  localparam logic [3:0] VOL_OFF = 4'hF;

  // Latched register address
  typedef struct packed {
    logic [1:0] ch;
    logic       typ;
  } lat_t;

  localparam lat_t LAT_RST = '{ch: CH_TONE0, typ: RT_TONE};

  // The noise control register sits where channel 3's tone period would be
  function automatic logic is_noise_ctrl(input lat_t l);
    return (l.ch == CH_NOISE) && (l.typ == RT_TONE);
  endfunction

endpackage

// File: rtl/jt89_wr_edge.sv
// jt89_wr_edge: turns the CPU chip-select/write strobe into a single-cycle write enable.
// Ports: clk/rst (sync, active-high); cs_n, wr_n active-low bus strobes; we = one-cycle
// pulse, combinational, high in the cycle whose closing edge accepts the write.
module jt89_wr_edge (
  input  logic clk,
  input  logic rst,
  input  logic cs_n,
  input  logic wr_n,
  output logic we
);

  logic w_s;
  logic r_s_q;

  assign w_s = ~cs_n & ~wr_n;

  // s_q resets high so a strobe already asserted when reset releases is not a write
  always_ff @(posedge clk) begin
    if (rst) r_s_q <= 1'b1;
    else     r_s_q <= w_s;
  end

  assign we = w_s & ~r_s_q;

endmodule

// File: rtl/jt89_cpu_if.sv
// jt89_cpu_if: SN76489 byte-write decoder feeding the tone/noise channel register file,
// plus the READY handshake. Register outputs update on the accepting edge (1 clk latency).
// Ports: clk, rst (sync, active-high), cs_n/wr_n/din CPU bus; ready; tone0..2, vol0..3,
// ctrl3, clr (one-cycle noise LFSR clear). Writes are never dropped: a write while
// ready=0 still executes and restarts the READY count.
module jt89_cpu_if
  import jt89_pkg::*;
#(
  parameter int unsigned READY_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic [7:0] din,
  output logic       ready,
  output logic [9:0] tone0,
  output logic [9:0] tone1,
  output logic [9:0] tone2,
  output logic [3:0] vol0,
  output logic [3:0] vol1,
  output logic [3:0] vol2,
  output logic [3:0] vol3,
  output logic [2:0] ctrl3,
  output logic       clr
);

  localparam logic [7:0] RDY_LOAD = READY_CYCLES[7:0];

  logic       w_we;
  lat_t       w_tgt;
  logic       w_latch;

  lat_t       r_lat;
  logic [9:0] r_tone0, r_tone1, r_tone2;
  logic [3:0] r_vol0, r_vol1, r_vol2, r_vol3;
  logic [2:0] r_ctrl3;
  logic       r_clr;
  logic [7:0] r_cnt;

  jt89_wr_edge u_wr_edge (
    .clk  (clk),
    .rst  (rst),
    .cs_n (cs_n),
    .wr_n (wr_n),
    .we   (w_we)
  );

  // A latch byte addresses its own target; a data byte reuses the previously latched one
  assign w_latch = din[7];
  assign w_tgt   = w_latch ? lat_t'({din[6:5], din[4]}) : r_lat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lat   <= LAT_RST;
      r_tone0 <= 10'd0;
      r_tone1 <= 10'd0;
      r_tone2 <= 10'd0;
      r_vol0  <= VOL_OFF;
      r_vol1  <= VOL_OFF;
      r_vol2  <= VOL_OFF;
      r_vol3  <= VOL_OFF;
      r_ctrl3 <= 3'd0;
      r_clr   <= 1'b0;
      r_cnt   <= 8'd0;
    end else begin
      r_clr <= 1'b0;
      // Saturating down-count; a new write reloads it
      if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;

      if (w_we) begin
        r_cnt <= RDY_LOAD;
        if (w_latch) r_lat <= w_tgt;

        if (w_tgt.typ == RT_VOL) begin
          case (w_tgt.ch)
            CH_TONE0: r_vol0 <= din[3:0];
            CH_TONE1: r_vol1 <= din[3:0];
            CH_TONE2: r_vol2 <= din[3:0];
            default:  r_vol3 <= din[3:0];
          endcase
        end else if (is_noise_ctrl(w_tgt)) begin
          r_ctrl3 <= din[2:0];
          r_clr   <= 1'b1;
        end else if (w_latch) begin
          // Latch byte carries the low nibble of the period
          case (w_tgt.ch)
            CH_TONE0: r_tone0[3:0] <= din[3:0];
            CH_TONE1: r_tone1[3:0] <= din[3:0];
            default:  r_tone2[3:0] <= din[3:0];
          endcase
        end else begin
          // Data byte carries the upper six bits of the period
          case (w_tgt.ch)
            CH_TONE0: r_tone0[9:4] <= din[5:0];
            CH_TONE1: r_tone1[9:4] <= din[5:0];
            default:  r_tone2[9:4] <= din[5:0];
          endcase
        end
      end
    end
  end

  assign ready = (r_cnt == 8'd0);
  assign tone0 = r_tone0;
  assign tone1 = r_tone1;
  assign tone2 = r_tone2;
  assign vol0  = r_vol0;
  assign vol1  = r_vol1;
  assign vol2  = r_vol2;
  assign vol3  = r_vol3;
  assign ctrl3 = r_ctrl3;
  assign clr   = r_clr;

endmodule

// File: tb/tb_jt89_cpu_if.sv
// tb_jt89_cpu_if: scoreboard bench for jt89_cpu_if. A driver issues bus writes and updates
// a behavioural register model; expected register snapshots are queued against the edge
// at which they must appear, and a negedge monitor compares them plus ready/clr each cycle.
module tb_jt89_cpu_if;

  localparam int RC = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs_n = 1'b1;
  logic       wr_n = 1'b1;
  logic [7:0] din = 8'h00;
  logic       ready;
  logic [9:0] tone0, tone1, tone2;
  logic [3:0] vol0, vol1, vol2, vol3;
  logic [2:0] ctrl3;
  logic       clr;

  jt89_cpu_if #(.READY_CYCLES(RC)) dut (
    .clk   (clk),
    .rst   (rst),
    .cs_n  (cs_n),
    .wr_n  (wr_n),
    .din   (din),
    .ready (ready),
    .tone0 (tone0),
    .tone1 (tone1),
    .tone2 (tone2),
    .vol0  (vol0),
    .vol1  (vol1),
    .vol2  (vol2),
    .vol3  (vol3),
    .ctrl3 (ctrl3),
    .clr   (clr)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Behavioural model of the chip's visible state
  int m_tone[3];
  int m_vol[4];
  int m_ctrl;
  int m_lch;
  int m_lvol;
  int last_acc = -100000;
  int clr_edge = -1;
  bit chk_en = 1'b0;

  typedef struct {
    int          e;
    logic [29:0] t;
    logic [15:0] v;
    logic [2:0]  c;
  } rec_t;
  rec_t q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic rec_t snap(input int e);
    rec_t r;
    r.e = e;
    r.t = {10'(m_tone[2]), 10'(m_tone[1]), 10'(m_tone[0])};
    r.v = {4'(m_vol[3]), 4'(m_vol[2]), 4'(m_vol[1]), 4'(m_vol[0])};
    r.c = 3'(m_ctrl);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_tone[i] = 0;
    for (int i = 0; i < 4; i++) m_vol[i] = 15;
    m_ctrl   = 0;
    m_lch    = 0;
    m_lvol   = 0;
    last_acc = -100000;
    clr_edge = -1;
    q.push_back(snap(edge_n));
  endtask

  // Apply one accepted byte to the model using the protocol rules directly
  task automatic model_write(input int d);
    int ch;
    int isvol;
    if (d >= 128) begin
      m_lch  = (d / 32) % 4;
      m_lvol = (d / 16) % 2;
    end
    ch    = m_lch;
    isvol = m_lvol;
    if (isvol == 1) begin
      m_vol[ch] = d % 16;
    end else if (ch == 3) begin
      m_ctrl   = d % 8;
      clr_edge = edge_n;
    end else if (d >= 128) begin
      m_tone[ch] = (m_tone[ch] / 16) * 16 + d % 16;
    end else begin
      m_tone[ch] = (d % 64) * 16 + m_tone[ch] % 16;
    end
    last_acc = edge_n;
    q.push_back(snap(edge_n));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One bus write: strobe low for `hold` edges, then released for one edge
  task automatic wr(input logic [7:0] d, input int hold);
    cs_n = 1'b0;
    wr_n = 1'b0;
    din  = d;
    @(posedge clk);
    #1;
    model_write(int'(d));
    din = 8'($urandom);
    repeat (hold - 1) begin
      @(posedge clk);
      #1;
    end
    if ($urandom_range(0, 1) == 1) cs_n = 1'b1;
    else                           wr_n = 1'b1;
    @(posedge clk);
    #1;
    cs_n = 1'b1;
    wr_n = 1'b1;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    rec_t r;
    if (chk_en) begin
      chk("ready", 64'(ready), 64'((edge_n - last_acc) >= RC));
      chk("clr", 64'(clr), 64'(edge_n == clr_edge));
      while (q.size() > 0 && q[0].e <= edge_n) begin
        r = q.pop_front();
        chk("snap_edge", 64'(r.e), 64'(edge_n));
        chk("regs", 64'({tone2, tone1, tone0, vol3, vol2, vol1, vol0, ctrl3}),
            64'({r.t, r.v, r.c}));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;

    // Reset with the strobe already held low
    rst  = 1'b1;
    cs_n = 1'b0;
    wr_n = 1'b0;
    din  = 8'h8A;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    chk_en = 1'b1;
    rst = 1'b0;
    idle(3);
    q.push_back(snap(edge_n));   // still reset values: held strobe was not a write
    @(negedge clk);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_vol0", 64'(vol0), 64'hF);
    cs_n = 1'b1;
    wr_n = 1'b1;
    idle(2);

    // Tone0 latch + data
    wr(8'h8E, 1);
    wr(8'h0F, 1);
    @(negedge clk);
    chk("tone0_fe", 64'(tone0), 64'h0FE);
    wr(8'h03, 1);
    @(negedge clk);
    chk("tone0_3e", 64'(tone0), 64'h03E);

    // Vol1 latch + data
    wr(8'hBF, 1);
    @(negedge clk);
    chk("vol1_f", 64'(vol1), 64'hF);
    wr(8'h02, 2);
    @(negedge clk);
    chk("vol1_2", 64'(vol1), 64'h2);
    chk("tone1_keep", 64'(tone1), 64'h0);

    // Noise control latch + data, each with its own clr pulse
    wr(8'hE5, 1);
    @(negedge clk);
    chk("ctrl3_5", 64'(ctrl3), 64'h5);
    wr(8'h03, 1);
    @(negedge clk);
    chk("ctrl3_3", 64'(ctrl3), 64'h3);
    chk("tone2_keep", 64'(tone2), 64'h0);

    // READY timing: restart at cycle 10, then a 100-cycle held strobe
    idle(RC + 4);
    wr(8'h90, 1);
    idle(8);
    wr(8'h91, 1);
    idle(RC + 6);
    wr(8'hC5, 100);
    idle(RC + 2);

    // Reset during busy, together with an asserted write strobe
    wr(8'h85, 1);
    idle(3);
    rst  = 1'b1;
    cs_n = 1'b0;
    wr_n = 1'b0;
    din  = 8'h9C;
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
    @(negedge clk);
    chk("busy_rst_ready", 64'(ready), 64'd1);
    chk("busy_rst_tone0", 64'(tone0), 64'h0);
    idle(2);
    cs_n = 1'b1;
    wr_n = 1'b1;
    idle(2);

    // Randomized traffic
    repeat (150) begin
      d = 8'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        // Half strobes are not writes
        if ($urandom_range(0, 1) == 1) cs_n = 1'b0;
        else                           wr_n = 1'b0;
        idle(1);
        cs_n = 1'b1;
        wr_n = 1'b1;
      end
      if ($urandom_range(0, 40) == 0) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
        idle(1);
      end
      wr(d, $urandom_range(1, 3));
      idle($urandom_range(0, 3));
    end

    idle(RC + 4);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
